// File: rtl/sci_alu_seq.sv
// sci_alu_seq -- clocked scientific ALU, unsigned WIDTH-bit operands.
//
// One operation in flight. Single-cycle ops (ADD/SUB/logic/shift/MIN/MAX,
// DIV by zero, illegal opcodes) go IDLE -> DONE on the accept edge.
// MUL (shift-add), DIV (restoring) and SQRT (bit-pair) iterate in BUSY.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and result/excep/err are held until out_valid & out_ready.
//
// Optional feature macro: SCI_ALU_SQRT_EN (opcode 4 = SQRT). When it is not
// defined there is no SQRT datapath and opcode 4 is an illegal opcode.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand-side handshake
//   a, b, opcode          operands and operation select (captured on accept)
//   out_valid / out_ready result-side handshake
//   result, excep, err    result, arithmetic exception, illegal opcode
//   dbg_state             current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module sci_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             excep,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LAST_WIDE = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_exc, r_err;

  // Single-cycle results, computed straight from the inputs for the accept edge.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_exc, w_err, w_iter;

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_res  = '0;
    w_exc  = 1'b0;
    w_err  = 1'b0;
    w_iter = 1'b0;
    case (opcode)
      4'd0: begin w_res = w_sum[WIDTH-1:0]; w_exc = w_sum[WIDTH]; end
      4'd1: begin w_res = a - b; w_exc = (a < b); end
      4'd2: w_iter = 1'b1;
      4'd3: begin
        if (b == '0) begin
          w_res = '1;
          w_exc = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
`ifdef SCI_ALU_SQRT_EN
      4'd4: w_iter = 1'b1;
`else
      4'd4: w_err = 1'b1;
`endif
      4'd5:  w_res = a & b;
      4'd6:  w_res = a | b;
      4'd7:  w_res = a ^ b;
      4'd8:  w_res = ~a;
      4'd9:  w_res = a << b[SHW-1:0];
      4'd10: w_res = a >> b[SHW-1:0];
      4'd11: w_res = (a < b) ? a : b;
      4'd12: w_res = (a < b) ? b : a;
      default: w_err = 1'b1;
    endcase
  end

  // MUL step: {hi,lo} holds partial product in hi and the unconsumed
  // multiplier bits in lo; add multiplicand if lo[0], then shift right.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_n, w_mul_lo_n;
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_hi_n = w_mul_sum[WIDTH:1];
  assign w_mul_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // DIV step: hi is the partial remainder (always < divisor), lo shifts the
  // dividend out at the top and collects quotient bits at the bottom.
  logic [WIDTH:0]   w_dv_sh;
  logic [WIDTH+1:0] w_dv_diff;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dv_rem_n, w_dv_quo_n;
  assign w_dv_sh    = {r_hi, r_lo[WIDTH-1]};
  assign w_dv_diff  = {1'b0, w_dv_sh} - {2'b00, r_b};
  assign w_dv_neg   = w_dv_diff[WIDTH+1];
  assign w_dv_rem_n = w_dv_neg ? w_dv_sh[WIDTH-1:0] : w_dv_diff[WIDTH-1:0];
  assign w_dv_quo_n = {r_lo[WIDTH-2:0], ~w_dv_neg};

`ifdef SCI_ALU_SQRT_EN
  // SQRT step: bring down the next two radicand bits (lo, MSB first) into
  // the remainder (hi) and try subtracting (4*root + 1).
  localparam logic [CW-1:0] LAST_HALF = CW'(WIDTH/2 - 1);
  logic [WIDTH-1:0] r_root;
  logic [WIDTH+1:0] w_sq_rs, w_sq_tr, w_sq_diff;
  logic             w_sq_ge;
  logic [WIDTH-1:0] w_sq_root_n, w_sq_rem_n;
  assign w_sq_rs     = {r_hi, r_lo[WIDTH-1:WIDTH-2]};
  assign w_sq_tr     = {r_root, 2'b01};
  assign w_sq_diff   = w_sq_rs - w_sq_tr;
  assign w_sq_ge     = (w_sq_rs >= w_sq_tr);
  assign w_sq_root_n = {r_root[WIDTH-2:0], w_sq_ge};
  assign w_sq_rem_n  = w_sq_ge ? w_sq_diff[WIDTH-1:0] : w_sq_rs[WIDTH-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_exc   <= 1'b0;
      r_err   <= 1'b0;
`ifdef SCI_ALU_SQRT_EN
      r_root  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= opcode;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= (opcode == 4'd2) ? b : a;
            r_res <= w_res;
            r_exc <= w_exc;
            r_err <= w_err;
`ifdef SCI_ALU_SQRT_EN
            r_root <= '0;
`endif
            r_state <= w_iter ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          case (r_op)
            4'd2: begin
              r_hi <= w_mul_hi_n;
              r_lo <= w_mul_lo_n;
              if (r_cnt == LAST_WIDE) begin
                r_res   <= w_mul_lo_n;
                r_exc   <= |w_mul_hi_n;
                r_state <= S_DONE;
              end
            end
            4'd3: begin
              r_hi <= w_dv_rem_n;
              r_lo <= w_dv_quo_n;
              if (r_cnt == LAST_WIDE) begin
                r_res   <= w_dv_quo_n;
                r_state <= S_DONE;
              end
            end
`ifdef SCI_ALU_SQRT_EN
            4'd4: begin
              r_hi   <= w_sq_rem_n;
              r_lo   <= {r_lo[WIDTH-3:0], 2'b00};
              r_root <= w_sq_root_n;
              if (r_cnt == LAST_HALF) begin
                r_res   <= w_sq_root_n;
                r_state <= S_DONE;
              end
            end
`endif
            default: r_state <= S_DONE;
          endcase
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_res;
  assign excep     = r_exc;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sci_alu_seq.sv
module tb_sci_alu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         excep;
  logic         err;
  logic [1:0]   dbg_state;

  always #5 clock = ~clock;

  sci_alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .excep(excep), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // packed expectation: {err, excep, result}
  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
    logic         er;
    int           lat;
    int           hold;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input logic e, input logic er,
                         input int lat, input int hold);
    vec_t v;
    v.op = op; v.a = x; v.b = y; v.res = r; v.exc = e; v.er = er; v.lat = lat; v.hold = hold;
    tbl.push_back(v);
  endtask

  // Reference model for random stimulus, built on wide integer arithmetic.
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [63:0]  p;
    logic [W-1:0] r;
    logic [W-1:0] t;
    logic         e;
    logic         er;
    r = '0; e = 1'b0; er = 1'b0;
    case (op)
      4'd0: begin p = {32'd0, x} + {32'd0, y}; r = p[W-1:0]; e = p[W]; end
      4'd1: begin r = x - y; e = (x < y); end
      4'd2: begin p = {32'd0, x} * {32'd0, y}; r = p[W-1:0]; e = (p[63:32] != 0); end
      4'd3: begin
        if (y == 0) begin r = '1; e = 1'b1; end
        else r = x / y;
      end
      4'd4: begin
`ifdef SCI_ALU_SQRT_EN
        for (int k = 15; k >= 0; k--) begin
          t = r | (32'd1 << k);
          if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) r = t;
        end
`else
        er = 1'b1;
`endif
      end
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = x ^ y;
      4'd8:  r = ~x;
      4'd9:  r = x << y[4:0];
      4'd10: r = x >> y[4:0];
      4'd11: r = (x < y) ? x : y;
      4'd12: r = (x > y) ? x : y;
      default: er = 1'b1;
    endcase
    return {er, e, r};
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] y);
    if (op == 4'd2) return W + 1;
    if (op == 4'd3 && y != 0) return W + 1;
`ifdef SCI_ALU_SQRT_EN
    if (op == 4'd4) return W/2 + 1;
`endif
    return 1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W+1:0] expv, input int lat, input int hold, input bit early);
    int guard;
    int n;
    logic [W+1:0] e;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; opcode = op; a = x; b = y;
    exp_q.push_back(expv);
    n_vec++;
    @(posedge clock);
    #1;
    // scramble inputs to confirm they were captured on accept
    in_valid = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    a = $urandom;
    b = $urandom;
    out_ready = early;
    n = 1;
    @(negedge clock);
    while (!out_valid && n < 100) begin
      if (n > 1) chk("in_ready_low_busy", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
      n++;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk("out_valid_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", {32'd0, result}, {32'd0, e[W-1:0]});
    chk("excep", {63'd0, excep}, {63'd0, e[W]});
    chk("err", {63'd0, err}, {63'd0, e[W+1]});
    chk("in_ready_low_done", {63'd0, in_ready}, 64'd0);
    if (!early) begin
      repeat (hold) begin
        @(negedge clock);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", {30'd0, err, excep, result}, {30'd0, e});
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("after_hs_out_valid", {63'd0, out_valid}, 64'd0);
    chk("after_hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0]   op;
    logic [W-1:0] x, y;
    int           seen;

    // directed vectors
    add_vec(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, 0);
    add_vec(4'd2, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 33, 0);
    add_vec(4'd2, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33, 1);
    add_vec(4'd3, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 0);
    add_vec(4'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0);
`ifdef SCI_ALU_SQRT_EN
    add_vec(4'd4, 32'h0100_0000, 32'h5, 32'h1000, 1'b0, 1'b0, 17, 0);
    add_vec(4'd4, 32'hFFFF_FFFF, 32'h0, 32'hFFFF, 1'b0, 1'b0, 17, 0);
`else
    add_vec(4'd4, 32'h0100_0000, 32'h5, 32'h0, 1'b0, 1'b1, 1, 0);
    add_vec(4'd4, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1, 1, 0);
`endif
    add_vec(4'hE, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1, 5);
    add_vec(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1, 0);
    add_vec(4'd1, 32'd7, 32'd5, 32'd2, 1'b0, 1'b0, 1, 2);
    add_vec(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1, 0);
    add_vec(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, 1, 0);
    add_vec(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0, 1, 0);
    add_vec(4'd8, 32'h1234_5678, 32'h0, 32'hEDCB_A987, 1'b0, 1'b0, 1, 0);
    add_vec(4'd9, 32'h1, 32'h25, 32'h20, 1'b0, 1'b0, 1, 0);
    add_vec(4'd10, 32'h8000_0000, 32'hFF, 32'h1, 1'b0, 1'b0, 1, 0);
    add_vec(4'd11, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, 1, 0);
    add_vec(4'd12, 32'd9, 32'd3, 32'd9, 1'b0, 1'b0, 1, 0);
    add_vec(4'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
    add_vec(4'd3, 32'd7, 32'd100, 32'd0, 1'b0, 1'b0, 33, 0);
    add_vec(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 33, 0);
    add_vec(4'hD, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1, 0);
    add_vec(4'hF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1, 0);

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_excep", {63'd0, excep}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].er, tbl[i].exc, tbl[i].res},
             tbl[i].lat, tbl[i].hold, 1'b0);

    // out_ready held high before out_valid: must simply complete on DONE
    run_op(4'd2, 32'd123, 32'd456, model(4'd2, 32'd123, 32'd456), W + 1, 0, 1'b1);

    // random ops against the model
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, x, y, model(op, x, y), model_lat(op, y),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a DIV
    @(negedge clock);
    in_valid = 1'b1; opcode = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("mid_div_state_busy", {62'd0, dbg_state}, 64'd1);
    chk("mid_div_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_op(4'd0, 32'd2, 32'd3, {2'b00, 32'd5}, 1, 0, 1'b0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
